// File: rtl/graphene_refresh_responder.sv
// rtl/graphene_refresh_responder.sv - acknowledges tracker alerts, queues aggressor rows, issues neighbour refreshes
// Optional duplicate suppression against queued and in-flight rows: GRAPHENE_RESP_DEDUP_EN
module graphene_refresh_responder #(
  parameter int ADDRESS_SIZE  = 16,
  parameter int FIFO_DEPTH    = 4,
  parameter int BLAST_RADIUS  = 1,
  parameter int DROP_CNT_SIZE = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     alert,
  input  logic [ADDRESS_SIZE-1:0]  ref_addr,
  output logic                     ref_read_en,
  output logic                     rfm_valid,
  output logic [ADDRESS_SIZE-1:0]  rfm_row,
  input  logic                     rfm_ready,
  output logic                     busy,
  output logic                     fifo_full,
  output logic [DROP_CNT_SIZE-1:0] drop_cnt
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [3:0] OFF_START = 4'(-BLAST_RADIUS);
  localparam logic [3:0] OFF_END   = 4'(BLAST_RADIUS);

  typedef enum logic {IDLE, ISSUE} state_t;

  state_t                  state, state_next;
  logic [ADDRESS_SIZE-1:0] mem [FIFO_DEPTH];
  logic [PW:0]             wr_ptr, rd_ptr;
  logic                    guard;
  logic [ADDRESS_SIZE-1:0] aggr_q;
  logic [3:0]              offset;
  logic [ADDRESS_SIZE:0]   cand;
  logic                    in_range, empty, capture, dup, push, drop, pop;

  assign empty     = (wr_ptr == rd_ptr);
  assign fifo_full = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign busy      = !empty || (state != IDLE);

  // The pulse and the guard cycle after it block re-sampling of a still-high alert.
  assign capture = alert && !ref_read_en && !guard;

`ifdef GRAPHENE_RESP_DEDUP_EN
  logic [PW:0] count;
  assign count = wr_ptr - rd_ptr;

  always_comb begin
    dup = (state == ISSUE) && (aggr_q == ref_addr);
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      if (((PW+1)'(i) < count) && (mem[rd_ptr[PW-1:0] + PW'(i)] == ref_addr))
        dup = 1'b1;
    end
  end
`else
  assign dup = 1'b0;
`endif

  assign push = capture && !fifo_full && !dup;
  assign drop = capture && fifo_full && !dup;

  // One extra bit flags candidates below 0 or above the top row.
  assign cand     = {1'b0, aggr_q} + {{(ADDRESS_SIZE-3){offset[3]}}, offset};
  assign in_range = !cand[ADDRESS_SIZE];

  always_comb begin
    state_next = state;
    pop        = 1'b0;
    rfm_valid  = 1'b0;
    rfm_row    = '0;
    unique case (state)
      IDLE: begin
        if (!empty) begin
          pop        = 1'b1;
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        rfm_valid = in_range;
        rfm_row   = cand[ADDRESS_SIZE-1:0];
        if ((!in_range || rfm_ready) && (offset == OFF_END))
          state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr[PW-1:0]] <= ref_addr;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      guard       <= 1'b0;
      ref_read_en <= 1'b0;
      drop_cnt    <= '0;
      aggr_q      <= '0;
      offset      <= '0;
    end else begin
      state       <= state_next;
      ref_read_en <= capture;
      guard       <= ref_read_en;
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (drop && (drop_cnt != '1))
        drop_cnt <= drop_cnt + 1'b1;
      if (pop) begin
        aggr_q <= mem[rd_ptr[PW-1:0]];
        rd_ptr <= rd_ptr + 1'b1;
        offset <= OFF_START;
      end else if ((state == ISSUE) && (!in_range || rfm_ready)) begin
        // Offset zero is the aggressor itself and is never refreshed.
        offset <= (offset == 4'hF) ? 4'd1 : offset + 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_graphene_refresh_responder.sv
// tb/tb_graphene_refresh_responder.sv - randomized and directed checks against a queue-based reference model
module tb_graphene_refresh_responder;

  localparam int AW = 16;
  localparam int DEPTH = 4;
  localparam int R = 1;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          reset, alert, rfm_ready;
  logic [AW-1:0] ref_addr, rfm_row;
  logic          ref_read_en, rfm_valid, busy, fifo_full;
  logic [DW-1:0] drop_cnt;

  always #5 clk = ~clk;

  graphene_refresh_responder #(
    .ADDRESS_SIZE(AW), .FIFO_DEPTH(DEPTH), .BLAST_RADIUS(R), .DROP_CNT_SIZE(DW)
  ) dut (
    .clk(clk), .reset(reset), .alert(alert), .ref_addr(ref_addr),
    .ref_read_en(ref_read_en), .rfm_valid(rfm_valid), .rfm_row(rfm_row),
    .rfm_ready(rfm_ready), .busy(busy), .fifo_full(fifo_full), .drop_cnt(drop_cnt)
  );

  int checks = 0;
  int errors = 0;
  bit cmp_en = 0;

  typedef struct { bit v; logic [AW-1:0] row; } slot_t;
  logic [AW-1:0] m_fifo[$];
  slot_t         m_slots[$];
  bit            m_active = 0;
  logic [AW-1:0] m_aggr;
  int            m_since = 3;
  int            m_drop = 0;
  logic [AW-1:0] issued[$];
  int            pulses = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: an aggressor becomes a list of per-cycle slots (one per nonzero offset).
  always @(posedge clk) begin
    bit cap, full, dup;
    if (reset) begin
      m_fifo.delete();
      m_slots.delete();
      m_active = 0;
      m_since = 3;
      m_drop = 0;
    end else begin
      if (rfm_valid && rfm_ready) issued.push_back(rfm_row);
      cap  = alert && (m_since >= 3);
      full = (m_fifo.size() == DEPTH);
      dup  = 0;
`ifdef GRAPHENE_RESP_DEDUP_EN
      if (cap) begin
        if (m_active && m_aggr == ref_addr) dup = 1;
        foreach (m_fifo[i]) if (m_fifo[i] == ref_addr) dup = 1;
      end
`endif
      if (m_active) begin
        if (!m_slots[0].v || rfm_ready) void'(m_slots.pop_front());
        if (m_slots.size() == 0) m_active = 0;
      end else if (m_fifo.size() > 0) begin
        m_aggr = m_fifo.pop_front();
        for (int off = -R; off <= R; off++) begin
          if (off != 0) begin
            int c;
            slot_t s;
            c = int'(m_aggr) + off;
            s.v = (c >= 0) && (c < (1 << AW));
            s.row = c[AW-1:0];
            m_slots.push_back(s);
          end
        end
        m_active = 1;
      end
      if (cap && !dup) begin
        if (!full) m_fifo.push_back(ref_addr);
        else if (m_drop < (1 << DW) - 1) m_drop++;
      end
      m_since = cap ? 1 : ((m_since < 3) ? m_since + 1 : 3);
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      bit exp_v;
      exp_v = m_active && m_slots[0].v;
      chk("ref_read_en", 32'(ref_read_en), 32'(m_since == 1));
      chk("rfm_valid", 32'(rfm_valid), 32'(exp_v));
      if (exp_v) chk("rfm_row", 32'(rfm_row), 32'(m_slots[0].row));
      chk("busy", 32'(busy), 32'(m_active || m_fifo.size() > 0));
      chk("fifo_full", 32'(fifo_full), 32'(m_fifo.size() == DEPTH));
      chk("drop_cnt", 32'(drop_cnt), 32'(m_drop));
    end
  end

  always @(negedge clk) if (ref_read_en) pulses++;

  task automatic send_alert(input logic [AW-1:0] a);
    int n;
    alert = 1'b1;
    ref_addr = a;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!ref_read_en && n < 50);
    if (n >= 50) chk("ack_timeout", 32'(ref_read_en), 32'd1);
    alert = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) chk("idle_timeout", 32'(busy), 32'd0);
  endtask

  function automatic logic [AW-1:0] pick_addr();
    case ($urandom_range(0, 5))
      0: return 16'h0000;
      1: return 16'hFFFF;
      2: return 16'h0001;
      3: return 16'hFFFE;
      4: return 16'h0100 + 16'($urandom_range(0, 3));
      default: return 16'($urandom());
    endcase
  endfunction

  initial begin
    int p0, n;
    reset = 1'b1; alert = 1'b0; ref_addr = '0; rfm_ready = 1'b0;
    @(negedge clk); @(negedge clk);
    cmp_en = 1;
    chk("rst_ref_read_en", 32'(ref_read_en), 32'd0);
    chk("rst_rfm_valid", 32'(rfm_valid), 32'd0);
    chk("rst_rfm_row", 32'(rfm_row), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_fifo_full", 32'(fifo_full), 32'd0);
    chk("rst_drop_cnt", 32'(drop_cnt), 32'd0);

    // single alert, latency and order
    reset = 1'b0; rfm_ready = 1'b1; issued.delete();
    alert = 1'b1; ref_addr = 16'h1234;
    @(negedge clk);
    chk("t1_ack", 32'(ref_read_en), 32'd1);
    alert = 1'b0;
    @(negedge clk);
    chk("t1_v0", 32'(rfm_valid), 32'd1);
    chk("t1_row0", 32'(rfm_row), 32'h1233);
    @(negedge clk);
    chk("t1_v1", 32'(rfm_valid), 32'd1);
    chk("t1_row1", 32'(rfm_row), 32'h1235);
    @(negedge clk);
    chk("t1_busy", 32'(busy), 32'd0);
    chk("t1_count", 32'(issued.size()), 32'd2);

    // address boundaries, no wrap
    issued.delete();
    send_alert(16'h0000); wait_idle();
    chk("low_count", 32'(issued.size()), 32'd1);
    chk("low_row", 32'(issued[0]), 32'h0001);
    issued.delete();
    send_alert(16'hFFFF); wait_idle();
    chk("high_count", 32'(issued.size()), 32'd1);
    chk("high_row", 32'(issued[0]), 32'hFFFE);

    // back-pressure holds the request stable
    rfm_ready = 1'b0; issued.delete();
    send_alert(16'h2000);
    n = 0;
    while (!rfm_valid && n < 20) begin @(negedge clk); n++; end
    for (int i = 0; i < 5; i++) begin
      chk("stall_valid", 32'(rfm_valid), 32'd1);
      chk("stall_row", 32'(rfm_row), 32'h1FFF);
      @(negedge clk);
    end
    rfm_ready = 1'b1; wait_idle();
    chk("stall_count", 32'(issued.size()), 32'd2);
    chk("stall_first", 32'(issued[0]), 32'h1FFF);
    chk("stall_second", 32'(issued[1]), 32'h2001);

    // overflow: FSM held on an earlier aggressor, six more alerts
    rfm_ready = 1'b0;
    send_alert(16'h4000);
    @(negedge clk);
    p0 = pulses;
    for (int i = 0; i < 6; i++) send_alert(16'h3000 + 16'(i));
    @(negedge clk); @(negedge clk);
    chk("ovf_pulses", 32'(pulses - p0), 32'd6);
    chk("ovf_full", 32'(fifo_full), 32'd1);
    chk("ovf_drop", 32'(drop_cnt), 32'd2);
    rfm_ready = 1'b1; wait_idle();

    // duplicate aggressor
    rfm_ready = 1'b0; issued.delete();
    send_alert(16'h0100);
    send_alert(16'h0100);
    rfm_ready = 1'b1; wait_idle();
`ifdef GRAPHENE_RESP_DEDUP_EN
    chk("dup_count", 32'(issued.size()), 32'd2);
`else
    chk("dup_count", 32'(issued.size()), 32'd4);
`endif

    // reset mid-operation
    rfm_ready = 1'b0;
    for (int i = 0; i < 4; i++) send_alert(16'h5000 + 16'(i * 16));
    chk("mid_valid", 32'(rfm_valid), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    chk("mid_rst_valid", 32'(rfm_valid), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    reset = 1'b0; rfm_ready = 1'b1; issued.delete();
    repeat (20) @(negedge clk);
    chk("mid_rst_none", 32'(issued.size()), 32'd0);

    // randomized traffic
    repeat (3000) begin
      @(negedge clk);
      if (alert && ref_read_en) alert = 1'b0;
      if (!alert && $urandom_range(0, 3) == 0) begin
        alert = 1'b1;
        ref_addr = pick_addr();
      end
      rfm_ready = ($urandom_range(0, 9) < 6);
      reset = ($urandom_range(0, 599) == 0);
      if (reset) alert = 1'b0;
    end
    @(negedge clk);
    reset = 1'b0; alert = 1'b0; rfm_ready = 1'b1;
    wait_idle();
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/graphene_refresh_responder.md
# graphene_refresh_responder

Consumer side of the Graphene row-hammer tracker handshake. It samples the tracker's `alert`/`ref_addr`, acknowledges each alert with a one-cycle `ref_read_en` pulse, and queues aggressor rows in a small FIFO. It then issues targeted neighbour-row refresh requests (`aggressor ± 1..BLAST_RADIUS`) to the memory controller over a valid/ready interface. It sits between the tracker and the refresh-management port of the controller.

## Interface
- `ADDRESS_SIZE`, 16, row address width; must match the tracker.
- `FIFO_DEPTH`, 4, pending aggressor entries; power of two, ≥2.
- `BLAST_RADIUS`, 1, neighbour distance refreshed on each side; 1..4.
- `DROP_CNT_SIZE`, 8, width of the saturating dropped-alert counter.

- `clk`  in  1  single clock; all state changes on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `alert`  in  1  tracker alert level; held high until acknowledged.
- `ref_addr`  in  ADDRESS_SIZE  aggressor row; valid while `alert`=1.
- `ref_read_en`  out  1  registered acknowledge pulse to the tracker.
- `rfm_valid`  out  1  refresh request valid.
- `rfm_row`  out  ADDRESS_SIZE  victim row to refresh.
- `rfm_ready`  in  1  controller accepts the request when `rfm_valid && rfm_ready`.
- `busy`  out  1  high when the FIFO is non-empty or the issue FSM is not IDLE.
- `fifo_full`  out  1  FIFO occupancy == FIFO_DEPTH.
- `drop_cnt`  out  DROP_CNT_SIZE  alerts discarded; saturates at all-ones.

## Operation
- **Capture:** when `alert`=1, `ref_read_en`=0 and the guard bit is clear, the block captures `ref_addr` at the edge.
  - FIFO not full: the row is pushed.
  - FIFO full: the row is discarded and `drop_cnt` increments (saturating).
  - In both cases `ref_read_en` is 1 for exactly the next cycle.
- **Guard:** the guard bit is set during the cycle after the `ref_read_en` pulse. Alerts are ignored while `ref_read_en`=1 or the guard bit is set, so one alert is never counted twice.
- **Issue FSM states:**
  - IDLE: if the FIFO is non-empty, pop the head into `aggr_q`, set offset to −BLAST_RADIUS, and go to ISSUE.
  - ISSUE: the candidate is `aggr_q + offset`, with offset iterating −R…−1, +1…+R (0 is skipped).
    - `rfm_valid` = candidate within [0, 2^ADDRESS_SIZE−1]; there is no wrap-around.
    - An in-range candidate is held (`rfm_valid`, `rfm_row` stable) until `rfm_ready`, then the offset advances.
    - An out-of-range candidate is skipped in one cycle with `rfm_valid`=0.
    - After offset +R completes, go to IDLE.
- **Arithmetic:** candidate rows are computed in ADDRESS_SIZE+1 bits, signed; the extra bit detects underflow and overflow.
- **Simultaneous push and pop** in the same edge is legal; occupancy is unchanged.
- **FIFO_DEPTH** entries are usable; full and empty are distinguished by an extra pointer bit.

## Timing
- Reset values: `ref_read_en`=0, `rfm_valid`=0, `rfm_row`=0, `busy`=0, `fifo_full`=0, `drop_cnt`=0. FIFO is empty, FSM is IDLE, guard is clear.
- Reset mid-operation discards the FIFO and the in-flight request. `rfm_valid` is 0 in the cycle after the reset edge.
- Alert sampled at edge E0 (FIFO empty, FSM IDLE):
  - `ref_read_en`=1 in the cycle after E0.
  - Pop occurs at E1; `rfm_valid`=1 from E1 onward.
  - Alert-to-first-request latency is 2 edges.
- Maximum alert acceptance rate is one per 3 cycles: pulse, guard, sample.
- Per aggressor, the FSM spends 2·R issue states plus 1 IDLE cycle when `rfm_ready` is held high.
- `rfm_row` never changes while `rfm_valid`=1 and `rfm_ready`=0.
- `busy` is combinational from the FIFO and FSM state.

## Configuration
- `GRAPHENE_RESP_DEDUP_EN` defined:
  - Before a push, the captured row is compared against all valid FIFO entries and against `aggr_q` while the FSM is not IDLE.
  - On a match, the alert is still acknowledged with `ref_read_en`, but no push occurs and `drop_cnt` is unchanged.
  - The comparison is combinational within the capture cycle; acceptance latency is unchanged.
- Undefined: every acknowledged alert is pushed if there is space, including duplicates. The compare logic is absent.

## Test plan
- Reset, then a single alert with `ref_addr`=0x1234 and `rfm_ready`=1:
  - `ref_read_en` pulses 1 cycle after the alert.
  - Requests 0x1233 then 0x1235 appear on consecutive cycles starting 2 edges after the alert.
  - `busy` returns to 0.
- `ref_addr`=0x0000 with R=1:
  - Only 0x0001 is issued.
  - `ref_addr`=0xFFFF issues only 0xFFFE; no wrap.
- `rfm_ready` held 0 for 5 cycles on the first request: `rfm_valid` and `rfm_row` are stable for all 5 cycles, and the request completes when ready rises.
- 6 alerts spaced 3 cycles apart with `rfm_ready`=0 (depth 4):
  - 4 alerts are queued.
  - `fifo_full`=1 and `drop_cnt`=2.
  - All 6 alerts are acknowledged with exactly 6 `ref_read_en` pulses.
- Two alerts with 0x0100, with `GRAPHENE_RESP_DEDUP_EN` defined:
  - One FIFO entry; exactly 2 requests are issued.
  - Without the macro: 4 requests.
- `reset` asserted while `rfm_valid`=1 with 3 entries queued: `rfm_valid`=0 next cycle, `busy`=0, and no further requests are issued.
